ps2_scancode_decoder: RTL and testbench

Consumes the byte stream produced by the PS/2 keyboard receiver (scanCode/scanCodeReady) and interprets Set-2 scan codes: E0 (extended) and F0 (break) prefixes, shift and caps-lock state, and ASCII translation. Emits one key event per completed scan sequence and buffers printable characters in a small FIFO read by the CPU/terminal side.

---
 rtl/ps2_scancode_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
// Interprets the Set-2 scan-code byte stream coming out of the PS/2 receiver.
// Handles the E0 (extended) and F0 (break) prefixes, tracks shift and
// caps-lock state, and translates non-extended make codes to ASCII. Printable
// characters are queued in a small first-word-fall-through FIFO.
//
// Handshakes:
//   scanCode/scanCodeReady : a byte is taken on the rising edge of
//                            scanCodeReady. Holding it high takes the byte once.
//   charData/charValid/charRead : valid/ready style. charData is the FIFO
//                            head whenever charValid=1. A cycle with
//                            charRead=1 and charValid=1 pops the head at the
//                            clock edge. charRead is ignored while charValid=0.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   scanCode[7:0]     byte from the receiver
//   scanCodeReady     receiver byte-ready level/pulse
//   keyCode[7:0]      final code of the last complete sequence
//   keyExtended       last sequence carried E0
//   keyReleased       last sequence carried F0
//   keyStrobe         one-cycle pulse when the key* outputs change
//   shiftActive       left or right shift held
//   capsLock          caps-lock toggle state
//   charData[7:0]     FIFO head ASCII byte
//   charValid         FIFO non-empty
//   charRead          pop request
//   overflow          sticky: a character was dropped on a full FIFO
//   fsm_state[1:0]    prefix FSM state (0 IDLE, 1 EXT, 2 BRK, 3 EXT_BRK)
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4,
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scanCode,
  input  logic       scanCodeReady,
  output logic [7:0] keyCode,
  output logic       keyExtended,
  output logic       keyReleased,
  output logic       keyStrobe,
  output logic       shiftActive,
  output logic       capsLock,
  output logic [7:0] charData,
  output logic       charValid,
  input  logic       charRead,
  output logic       overflow,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

  state_t           state, next_state;
  logic             ready_prev;
  logic             shift_l, shift_r;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [7:0]       mem [FIFO_DEPTH];

  logic       accept, is_e0, is_f0;
  logic       emit, emit_ext, emit_rel;
  logic [8:0] ascii;
  logic       push_req, pop, full, do_write;

  // Returns {valid, byte}. Modifier keys and unmapped codes are invalid.
  function automatic logic [8:0] to_ascii(input logic [7:0] code,
                                          input logic shift, input logic caps);
    logic [7:0] ch;
    logic       ok;
    ch = 8'h00;
    ok = 1'b1;
    case (code)
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = shift ? ")" : "0";
      8'h16: ch = shift ? "!" : "1";
      8'h1E: ch = shift ? "@" : "2";
      8'h26: ch = shift ? "#" : "3";
      8'h25: ch = shift ? "$" : "4";
      8'h2E: ch = shift ? "%" : "5";
      8'h36: ch = shift ? "^" : "6";
      8'h3D: ch = shift ? "&" : "7";
      8'h3E: ch = shift ? "*" : "8";
      8'h46: ch = shift ? "(" : "9";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      8'h0D: ch = 8'h09;
      default: ok = 1'b0;
    endcase
    // Only the letter entries land in 'a'..'z'; caps lock affects just those.
    if (ok && ch >= "a" && ch <= "z" && (shift ^ caps)) ch = ch - 8'h20;
    return {ok, ch};
  endfunction

  assign accept = scanCodeReady & ~ready_prev;
  assign is_e0  = (scanCode == 8'hE0);
  assign is_f0  = (scanCode == 8'hF0);

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_rel   = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (is_e0)      next_state = EXT;
          else if (is_f0) next_state = BRK;
          else            emit = 1'b1;
        end
        EXT: begin
          if (is_f0)      next_state = EXT_BRK;
          else if (is_e0) next_state = EXT;
          else begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            next_state = IDLE;
          end
        end
        BRK: begin
          // A prefix after F0 is malformed: drop the sequence silently.
          next_state = IDLE;
          if (!(is_e0 || is_f0)) begin
            emit     = 1'b1;
            emit_rel = 1'b1;
          end
        end
        default: begin
          next_state = IDLE;
          if (!(is_e0 || is_f0)) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_rel = 1'b1;
          end
        end
      endcase
    end
  end

  assign ascii     = to_ascii(scanCode, shiftActive, capsLock);
  assign push_req  = emit & ~emit_ext & ~emit_rel & ascii[8];
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign charValid = (count != '0);
  assign pop       = charRead & charValid;
  // On a full FIFO a same-cycle pop frees the slot the push needs.
  assign do_write  = push_req & (~full | pop);

  assign shiftActive = shift_l | shift_r;
  assign charData    = charValid ? mem[rd_ptr] : 8'h00;
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ready_prev  <= 1'b0;
      keyCode     <= 8'h00;
      keyExtended <= 1'b0;
      keyReleased <= 1'b0;
      keyStrobe   <= 1'b0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      capsLock    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      ready_prev <= scanCodeReady;
      state      <= next_state;
      keyStrobe  <= emit;
      if (emit) begin
        keyCode     <= scanCode;
        keyExtended <= emit_ext;
        keyReleased <= emit_rel;
      end
      if (emit && !emit_ext) begin
        if (scanCode == 8'h12) shift_l <= ~emit_rel;
        if (scanCode == 8'h59) shift_r <= ~emit_rel;
        if (scanCode == 8'h58 && !emit_rel) capsLock <= ~capsLock;
      end
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= ascii[7:0];
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Testbench for ps2_scancode_decoder: byte-level stimulus with queued
// expectations for key events and FIFO characters.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] scanCode = 8'h00;
  logic       scanCodeReady = 1'b0;
  logic       charRead = 1'b0;
  logic [7:0] keyCode, charData;
  logic       keyExtended, keyReleased, keyStrobe;
  logic       shiftActive, capsLock, charValid, overflow;
  logic [1:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  logic [9:0] exp_q[$];   // {keyCode, ext, rel}
  logic [7:0] char_q[$];  // expected FIFO contents in order

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .scanCode(scanCode), .scanCodeReady(scanCodeReady),
    .keyCode(keyCode), .keyExtended(keyExtended), .keyReleased(keyReleased),
    .keyStrobe(keyStrobe), .shiftActive(shiftActive), .capsLock(capsLock),
    .charData(charData), .charValid(charValid), .charRead(charRead),
    .overflow(overflow), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Key-event scoreboard: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (keyStrobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) check("unexpected_strobe", {keyCode, keyExtended, keyReleased}, 32'h0);
      else check("key_event", {keyCode, keyExtended, keyReleased}, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic expect_key(input logic [7:0] code, input logic ext, input logic rel);
    exp_q.push_back({code, ext, rel});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scanCode = b;
    scanCodeReady = 1'b1;
    @(negedge clk);
    scanCodeReady = 1'b0;
    @(negedge clk);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic read_char();
    logic [7:0] e;
    @(negedge clk);
    check("char_valid", charValid, 1'b1);
    e = (char_q.size() != 0) ? char_q.pop_front() : 8'hXX;
    check("char_data", charData, e);
    charRead = 1'b1;
    @(negedge clk);
    charRead = 1'b0;
  endtask

  int s0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_keyCode", keyCode, 8'h00);
    check("rst_flags", {keyExtended, keyReleased, keyStrobe, shiftActive, capsLock}, 5'b0);
    check("rst_char", {charValid, charData}, 9'h000);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst = 1'b1;

    // Plain make of 'a'
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h61);
    send_byte(8'h1C);
    read_char();
    check("empty_after_read", charValid, 1'b0);

    // Shift make/break around letters
    expect_key(8'h12, 0, 0); send_byte(8'h12);
    check("shift_on", shiftActive, 1'b1);
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h41); send_byte(8'h1C);
    expect_key(8'h16, 0, 0); char_q.push_back(8'h21); send_byte(8'h16);
    expect_key(8'h1C, 0, 1); send_byte(8'hF0); send_byte(8'h1C);
    expect_key(8'h12, 0, 1); send_byte(8'hF0); send_byte(8'h12);
    check("shift_off", shiftActive, 1'b0);
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h61); send_byte(8'h1C);
    expect_key(8'h29, 0, 0); char_q.push_back(8'h20); send_byte(8'h29);
    repeat (4) read_char();
    check("empty_after_shift", charValid, 1'b0);

    // Extended make and break: no characters, shift untouched
    expect_key(8'h75, 1, 0); send_byte(8'hE0); send_byte(8'h75);
    check("ext_keyExtended", keyExtended, 1'b1);
    expect_key(8'h75, 1, 1); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check("ext_shift", shiftActive, 1'b0);
    check("ext_no_char", charValid, 1'b0);
    check("ext_state_idle", fsm_state, 2'd0);

    // Caps lock: digits unaffected, letters upper case
    expect_key(8'h58, 0, 0); send_byte(8'h58);
    check("caps_on", capsLock, 1'b1);
    expect_key(8'h58, 0, 1); send_byte(8'hF0); send_byte(8'h58);
    check("caps_break_noop", capsLock, 1'b1);
    expect_key(8'h16, 0, 0); char_q.push_back(8'h31); send_byte(8'h16);
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h41); send_byte(8'h1C);
    read_char(); read_char();
    expect_key(8'h58, 0, 0); send_byte(8'h58);
    check("caps_off", capsLock, 1'b0);

    // Overflow: five pushes into a depth-4 FIFO
    repeat (5) expect_key(8'h1C, 0, 0);
    repeat (4) char_q.push_back(8'h61);
    repeat (5) send_byte(8'h1C);
    check("overflow_set", overflow, 1'b1);
    // Push together with a pop on a full FIFO: nothing dropped
    expect_key(8'h15, 0, 0);
    @(negedge clk);
    check("full_head", charData, char_q.pop_front());
    scanCode = 8'h15; scanCodeReady = 1'b1; charRead = 1'b1;
    @(negedge clk);
    scanCodeReady = 1'b0; charRead = 1'b0;
    char_q.push_back(8'h71);
    @(negedge clk);
    repeat (4) read_char();
    check("empty_after_drain", charValid, 1'b0);
    check("overflow_sticky", overflow, 1'b1);

    // Ready held high for 50 cycles: one accept only
    s0 = strobe_cnt;
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h61);
    @(negedge clk);
    scanCode = 8'h1C; scanCodeReady = 1'b1;
    repeat (50) @(negedge clk);
    scanCodeReady = 1'b0;
    @(negedge clk);
    check("held_one_strobe", strobe_cnt - s0, 1);
    read_char();
    check("held_one_char", charValid, 1'b0);

    // Reset mid-sequence drops the pending F0
    send_byte(8'hF0);
    check("brk_pending", fsm_state, 2'd2);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check("rst_clears_overflow", overflow, 1'b0);
    expect_key(8'h1C, 0, 0); char_q.push_back(8'h61);
    send_byte(8'h1C);
    check("post_rst_released", keyReleased, 1'b0);
    read_char();

    repeat (3) @(negedge clk);
    check("key_q_drained", exp_q.size(), 0);
    check("char_q_drained", char_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
